// File: rtl/dm_ctrl_pkg.sv
// Shared definitions for the handshaked data memory (dm_ctrl).
// Contents:
//   mem_type_e   - access size codes (word / halfword / byte / reserved)
//   MEM_SIGNED / MEM_UNSIGNED - load extension selector values
//   state_e      - controller states CLEAR / IDLE / WAIT / RESP
//   type_misaligned() - alignment / reserved-type check on the low address bits
package dm_ctrl_pkg;

  typedef enum logic [1:0] {
    MEM_W    = 2'b00,
    MEM_H    = 2'b01,
    MEM_B    = 2'b10,
    MEM_RSVD = 2'b11
  } mem_type_e;

  localparam logic MEM_SIGNED   = 1'b1;
  localparam logic MEM_UNSIGNED = 1'b0;

  localparam int LATENCY_MAX = 8;

  typedef enum logic [1:0] {
    CLEAR = 2'b00,
    IDLE  = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } state_e;

  // True when the access size does not fit the byte offset, or the size code
  // is the reserved one.
  function automatic logic type_misaligned(input logic [1:0] typ, input logic [1:0] addr_lo);
    logic bad;
    case (mem_type_e'(typ))
      MEM_W:   bad = (addr_lo != 2'b00);
      MEM_H:   bad = addr_lo[0];
      MEM_B:   bad = 1'b0;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dm_ctrl_if.sv
// Request / response bundle of the data memory.
//   req_valid/req_ready  - request handshake (master -> slave / slave -> master)
//   req_we, req_type, req_signed, req_addr, req_wdata, req_pc - request fields
//   resp_valid           - one-cycle completion pulse
//   resp_rdata, resp_err - formatted load data / rejection flag, held until next response
//   log_valid, log_pc, log_addr, log_word - store-commit record, presented alongside
//                          the response of a committed store so a simulation wrapper
//                          can print "%d@%h: *%h <= %h"
interface dm_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_type;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        log_valid;
  logic [31:0] log_pc;
  logic [31:0] log_addr;
  logic [31:0] log_word;

  modport master (
    output req_valid, req_we, req_type, req_signed, req_addr, req_wdata, req_pc,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  log_valid, log_pc, log_addr, log_word
  );

  modport slave (
    input  req_valid, req_we, req_type, req_signed, req_addr, req_wdata, req_pc,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output log_valid, log_pc, log_addr, log_word
  );
endinterface

// File: rtl/dm_lane_fmt.sv
// Byte-lane formatter for the data memory (purely combinational).
//   typ, sgn, addr_lo - access size, sign-extension select, byte offset in word
//   old_word          - current contents of the addressed word
//   wdata             - store data (low 8/16 bits used for B/H)
//   load_data         - selected lane, sign- or zero-extended to 32 bits
//   store_word        - old_word with the store data merged into its lane
module dm_lane_fmt
  import dm_ctrl_pkg::*;
(
  input  logic [1:0]  typ,
  input  logic        sgn,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel   = old_word[{addr_lo, 3'b000} +: 8];
    half_sel   = addr_lo[1] ? old_word[31:16] : old_word[15:0];
    load_data  = old_word;
    store_word = old_word;
    case (mem_type_e'(typ))
      MEM_W: store_word = wdata;
      MEM_H: begin
        load_data = {{16{sgn & half_sel[15]}}, half_sel};
        if (addr_lo[1]) store_word[31:16] = wdata[15:0];
        else            store_word[15:0]  = wdata[15:0];
      end
      MEM_B: begin
        load_data = {{24{sgn & byte_sel[7]}}, byte_sel};
        store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_ctrl.sv
// Handshaked data memory for the MEM stage of the pipelined MIPS core.
// One word/halfword/byte access at a time; response LATENCY cycles after
// acceptance. Misaligned, out-of-range and reserved-type accesses are
// rejected with resp_err. After reset the array is swept to zero, one word
// per cycle, before the first request is accepted.
//   clk, reset - clock and synchronous active-high reset
//   bus        - dm_ctrl_if slave port (request, response and store log)
//   busy       - low only in IDLE, or in RESP with no new acceptance
module dm_ctrl
  import dm_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 1
) (
  input  logic     clk,
  input  logic     reset,
  dm_ctrl_if.slave bus,
  output logic     busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  // WAIT lasts LATENCY-1 cycles: entered with LATENCY-2, leaves on 0.
  localparam logic [2:0] CNT_INIT = 3'(LATENCY > 1 ? LATENCY - 2 : 0);

  state_e                state;
  logic [ADDR_WIDTH-1:0] clr_idx;
  logic [2:0]            cnt;
  logic                  ready;
  logic                  resp_valid;
  logic                  resp_err;
  logic [31:0]           resp_rdata;
  logic                  log_valid;
  logic [31:0]           log_pc;
  logic [31:0]           log_addr;
  logic [31:0]           log_word;

  logic                  r_we;
  logic [1:0]            r_type;
  logic                  r_signed;
  logic [31:0]           r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_pc;

  logic                  a_we;
  logic [1:0]            a_type;
  logic                  a_signed;
  logic [31:0]           a_addr;
  logic [31:0]           a_wdata;
  logic [31:0]           a_pc;
  logic                  a_err;
  logic [ADDR_WIDTH-1:0] a_idx;

  logic                  accept;
  logic                  enter_resp;
  logic                  commit;
  logic [31:0]           old_word;
  logic [31:0]           load_data;
  logic [31:0]           store_word;

  logic [31:0]           mem [DEPTH];

  // Any address bit above the array is an error rather than a wrap.
  function automatic logic range_err(input logic [31:0] addr);
    return (addr >> (ADDR_WIDTH + 2)) != 32'd0;
  endfunction

  assign accept = bus.req_valid && ready;
  assign busy   = !((state == IDLE) || ((state == RESP) && !accept));

  // With LATENCY=1 the edge that accepts a request is also the edge that
  // enters RESP, so the access must be served from the live request fields;
  // otherwise it is served from the fields registered at acceptance.
  always_comb begin
    if (LATENCY == 1) begin
      a_we     = bus.req_we;
      a_type   = bus.req_type;
      a_signed = bus.req_signed;
      a_addr   = bus.req_addr;
      a_wdata  = bus.req_wdata;
      a_pc     = bus.req_pc;
      enter_resp = accept;
    end else begin
      a_we     = r_we;
      a_type   = r_type;
      a_signed = r_signed;
      a_addr   = r_addr;
      a_wdata  = r_wdata;
      a_pc     = r_pc;
      enter_resp = (state == WAIT) && (cnt == 3'd0);
    end
  end

  assign a_err    = type_misaligned(a_type, a_addr[1:0]) || range_err(a_addr);
  assign a_idx    = a_addr[ADDR_WIDTH+1:2];
  assign old_word = mem[a_idx];
  assign commit   = enter_resp && a_we && !a_err && !reset;

  dm_lane_fmt u_fmt (
    .typ        (a_type),
    .sgn        (a_signed),
    .addr_lo    (a_addr[1:0]),
    .old_word   (old_word),
    .wdata      (a_wdata),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // Controller: state, clear sweep, latency count, registered handshake/response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CLEAR;
      clr_idx    <= '0;
      cnt        <= '0;
      ready      <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      log_valid  <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == '1) begin
            state <= IDLE;
            ready <= 1'b1;
          end
        end
        IDLE, RESP: begin
          if (accept) begin
            if (LATENCY == 1) begin
              state <= RESP;
              ready <= 1'b1;
            end else begin
              state <= WAIT;
              ready <= 1'b0;
              cnt   <= CNT_INIT;
            end
          end else begin
            state <= IDLE;
            ready <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt == 3'd0) begin
            state <= RESP;
            ready <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= CLEAR;
          ready <= 1'b0;
        end
      endcase
      resp_valid <= enter_resp;
      log_valid  <= commit;
      if (enter_resp) begin
        resp_err   <= a_err;
        resp_rdata <= (a_err || a_we) ? 32'd0 : load_data;
      end
    end
  end

  // Request capture at acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      r_we     <= bus.req_we;
      r_type   <= bus.req_type;
      r_signed <= bus.req_signed;
      r_addr   <= bus.req_addr;
      r_wdata  <= bus.req_wdata;
      r_pc     <= bus.req_pc;
    end
  end

  // Store log record, valid in the same cycle as the store's response.
  always_ff @(posedge clk) begin
    if (commit) begin
      log_pc   <= a_pc;
      log_addr <= {a_addr[31:2], 2'b00};
      log_word <= store_word;
    end
  end

  // Array: clear sweep has priority; a store commits on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (!reset && (state == CLEAR)) mem[clr_idx] <= '0;
    else if (commit)                mem[a_idx]   <= store_word;
  end

  assign bus.req_ready  = ready;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_rdata = resp_rdata;
  assign bus.resp_err   = resp_err;
  assign bus.log_valid  = log_valid;
  assign bus.log_pc     = log_pc;
  assign bus.log_addr   = log_addr;
  assign bus.log_word   = log_word;

endmodule

// File: tb/tb_dm_ctrl.sv
// Scoreboard bench for dm_ctrl: one instance with LATENCY=3, one with
// LATENCY=1, both ADDR_WIDTH=4 (16 words).
module tb_dm_ctrl;
  import dm_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst3 = 1'b1;
  logic rst1 = 1'b1;
  logic busy3, busy1;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  dm_ctrl_if if3();
  dm_ctrl_if if1();

  dm_ctrl #(.ADDR_WIDTH(4), .LATENCY(3)) u_dut3 (.clk(clk), .reset(rst3), .bus(if3), .busy(busy3));
  dm_ctrl #(.ADDR_WIDTH(4), .LATENCY(1)) u_dut1 (.clk(clk), .reset(rst1), .bus(if1), .busy(busy1));

  typedef struct { logic [31:0] rd; logic err; longint at; } resp_t;
  typedef struct { logic [31:0] pc; logic [31:0] addr; logic [31:0] word; } log_t;

  resp_t rq3[$];
  resp_t rq1[$];
  log_t  lq3[$];
  log_t  lq1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 3) ? if3.req_ready : if1.req_ready;
  endfunction

  // Issue one request; when track is set, push the expected response (and
  // the expected log record for a committed store). expv is the load result
  // for loads and the resulting full word for stores.
  task automatic issue(input int sel, input logic we, input logic [1:0] t, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] pc,
                       input logic [31:0] expv, input logic exp_err, input bit track);
    int n;
    resp_t e;
    log_t l;
    @(negedge clk);
    if (sel == 3) begin
      if3.req_we = we; if3.req_type = t; if3.req_signed = sg;
      if3.req_addr = a; if3.req_wdata = wd; if3.req_pc = pc; if3.req_valid = 1'b1;
    end else begin
      if1.req_we = we; if1.req_type = t; if1.req_signed = sg;
      if1.req_addr = a; if1.req_wdata = wd; if1.req_pc = pc; if1.req_valid = 1'b1;
    end
    n = 0;
    while (rdy(sel) !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL issue_timeout: dut%0d req_ready stayed low for %0d cycles, want high", sel, n);
    end else if (track) begin
      e.rd  = (we || exp_err) ? 32'd0 : expv;
      e.err = exp_err;
      e.at  = cyc + ((sel == 3) ? 3 : 1);
      l.pc = pc; l.addr = {a[31:2], 2'b00}; l.word = expv;
      if (sel == 3) begin
        rq3.push_back(e);
        if (we && !exp_err) lq3.push_back(l);
      end else begin
        rq1.push_back(e);
        if (we && !exp_err) lq1.push_back(l);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drop(input int sel);
    if (sel == 3) if3.req_valid = 1'b0;
    else          if1.req_valid = 1'b0;
  endtask

  // Called at the negedge where reset is released.
  task automatic wait_clear(input int sel, input string name);
    longint start;
    int n;
    start = cyc;
    n = 0;
    while (rdy(sel) !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(cyc - start), 32'd16);
  endtask

  task automatic check_reset3(input string tag);
    check({tag, "_ready"}, 32'(if3.req_ready), 32'd0);
    check({tag, "_busy"},  32'(busy3), 32'd1);
    check({tag, "_rvalid"}, 32'(if3.resp_valid), 32'd0);
    check({tag, "_rdata"}, if3.resp_rdata, 32'd0);
    check({tag, "_rerr"},  32'(if3.resp_err), 32'd0);
  endtask

  // Response / log monitor for the LATENCY=3 instance.
  always @(negedge clk) begin
    resp_t e;
    log_t l;
    if (if3.resp_valid === 1'b1) begin
      if (rq3.size() == 0) begin
        total++; bad++;
        $display("FAIL d3_spurious_resp: got resp_valid=1 at cycle %0d, want none", cyc);
      end else begin
        e = rq3.pop_front();
        check("d3_rdata", if3.resp_rdata, e.rd);
        check("d3_err", 32'(if3.resp_err), 32'(e.err));
        check("d3_resp_cycle", 32'(cyc), 32'(e.at));
      end
    end
    if (if3.log_valid === 1'b1) begin
      $display("%d@%h: *%h <= %h", $time, if3.log_pc, if3.log_addr, if3.log_word);
      if (lq3.size() == 0) begin
        total++; bad++;
        $display("FAIL d3_spurious_log: got log at cycle %0d, want none", cyc);
      end else begin
        l = lq3.pop_front();
        check("d3_log_pc", if3.log_pc, l.pc);
        check("d3_log_addr", if3.log_addr, l.addr);
        check("d3_log_word", if3.log_word, l.word);
      end
    end
  end

  // Response / log monitor for the LATENCY=1 instance.
  always @(negedge clk) begin
    resp_t e;
    log_t l;
    if (if1.resp_valid === 1'b1) begin
      if (rq1.size() == 0) begin
        total++; bad++;
        $display("FAIL d1_spurious_resp: got resp_valid=1 at cycle %0d, want none", cyc);
      end else begin
        e = rq1.pop_front();
        check("d1_rdata", if1.resp_rdata, e.rd);
        check("d1_err", 32'(if1.resp_err), 32'(e.err));
        check("d1_resp_cycle", 32'(cyc), 32'(e.at));
      end
    end
    if (if1.log_valid === 1'b1) begin
      $display("%d@%h: *%h <= %h", $time, if1.log_pc, if1.log_addr, if1.log_word);
      if (lq1.size() == 0) begin
        total++; bad++;
        $display("FAIL d1_spurious_log: got log at cycle %0d, want none", cyc);
      end else begin
        l = lq1.pop_front();
        check("d1_log_pc", if1.log_pc, l.pc);
        check("d1_log_addr", if1.log_addr, l.addr);
        check("d1_log_word", if1.log_word, l.word);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    if3.req_valid = 1'b0; if3.req_we = 1'b0; if3.req_type = MEM_W; if3.req_signed = MEM_UNSIGNED;
    if3.req_addr = '0; if3.req_wdata = '0; if3.req_pc = '0;
    if1.req_valid = 1'b0; if1.req_we = 1'b0; if1.req_type = MEM_W; if1.req_signed = MEM_UNSIGNED;
    if1.req_addr = '0; if1.req_wdata = '0; if1.req_pc = '0;

    // One reset cycle, then the clear sweep.
    @(negedge clk);
    check_reset3("d3_reset");
    check("d1_reset_ready", 32'(if1.req_ready), 32'd0);
    rst3 = 1'b0;
    rst1 = 1'b0;
    wait_clear(3, "d3_clear_cycles");
    check("d1_ready_after_clear", 32'(if1.req_ready), 32'd1);
    check("d3_idle_busy", 32'(busy3), 32'd0);

    // Every word reads zero after the sweep.
    for (int i = 0; i < 16; i++)
      issue(3, 1'b0, MEM_W, MEM_UNSIGNED, 32'(i * 4), 32'd0, 32'h0040_0000, 32'd0, 1'b0, 1'b1);

    // LATENCY=3 directed accesses.
    issue(3, 1'b1, MEM_W, MEM_UNSIGNED, 32'h8, 32'h1234_5678, 32'h0040_0100, 32'h1234_5678, 1'b0, 1'b1);
    issue(3, 1'b0, MEM_B, MEM_SIGNED,   32'hB, 32'd0, 32'h0040_0104, 32'h0000_0012, 1'b0, 1'b1);
    issue(3, 1'b0, MEM_H, MEM_UNSIGNED, 32'hA, 32'd0, 32'h0040_0108, 32'h0000_1234, 1'b0, 1'b1);
    issue(3, 1'b1, MEM_B, MEM_UNSIGNED, 32'h5, 32'hABCD_EF80, 32'h0040_0110, 32'h0000_8000, 1'b0, 1'b1);
    issue(3, 1'b0, MEM_B, MEM_SIGNED,   32'h5, 32'd0, 32'h0040_0114, 32'hFFFF_FF80, 1'b0, 1'b1);
    issue(3, 1'b0, MEM_B, MEM_UNSIGNED, 32'h5, 32'd0, 32'h0040_0118, 32'h0000_0080, 1'b0, 1'b1);
    issue(3, 1'b0, MEM_H, MEM_SIGNED,   32'h4, 32'd0, 32'h0040_011C, 32'hFFFF_8000, 1'b0, 1'b1);
    issue(3, 1'b1, MEM_H, MEM_UNSIGNED, 32'hA, 32'h0000_BEEF, 32'h0040_0120, 32'hBEEF_5678, 1'b0, 1'b1);
    issue(3, 1'b0, MEM_W, MEM_SIGNED,   32'h8, 32'd0, 32'h0040_0124, 32'hBEEF_5678, 1'b0, 1'b1);
    issue(3, 1'b0, MEM_H, MEM_SIGNED,   32'h8, 32'd0, 32'h0040_0128, 32'h0000_5678, 1'b0, 1'b1);
    issue(3, 1'b0, MEM_B, MEM_UNSIGNED, 32'h9, 32'd0, 32'h0040_012C, 32'h0000_0056, 1'b0, 1'b1);

    // Rejected accesses: no data, error flag, no array change.
    issue(3, 1'b0, MEM_W,    MEM_UNSIGNED, 32'h6,  32'd0, 32'h0040_0200, 32'd0, 1'b1, 1'b1);
    issue(3, 1'b0, MEM_H,    MEM_UNSIGNED, 32'h3,  32'd0, 32'h0040_0204, 32'd0, 1'b1, 1'b1);
    issue(3, 1'b0, MEM_RSVD, MEM_UNSIGNED, 32'h0,  32'd0, 32'h0040_0208, 32'd0, 1'b1, 1'b1);
    issue(3, 1'b0, MEM_W,    MEM_UNSIGNED, 32'h40, 32'd0, 32'h0040_020C, 32'd0, 1'b1, 1'b1);
    issue(3, 1'b1, MEM_W,    MEM_UNSIGNED, 32'h40, 32'hDEAD_BEEF, 32'h0040_0210, 32'd0, 1'b1, 1'b1);
    issue(3, 1'b1, MEM_H,    MEM_UNSIGNED, 32'h9,  32'h0000_FFFF, 32'h0040_0214, 32'd0, 1'b1, 1'b1);
    issue(3, 1'b1, MEM_B,    MEM_UNSIGNED, 32'h1000_0004, 32'h0000_00AA, 32'h0040_0218, 32'd0, 1'b1, 1'b1);
    issue(3, 1'b0, MEM_W, MEM_UNSIGNED, 32'h0, 32'd0, 32'h0040_0220, 32'h0000_0000, 1'b0, 1'b1);
    issue(3, 1'b0, MEM_W, MEM_UNSIGNED, 32'h4, 32'd0, 32'h0040_0224, 32'h0000_8000, 1'b0, 1'b1);
    issue(3, 1'b0, MEM_W, MEM_UNSIGNED, 32'h8, 32'd0, 32'h0040_0228, 32'hBEEF_5678, 1'b0, 1'b1);

    // Reset while a store sits in WAIT: dropped, clear reruns.
    issue(3, 1'b1, MEM_W, MEM_UNSIGNED, 32'hC, 32'hCAFE_F00D, 32'h0040_0300, 32'd0, 1'b0, 1'b0);
    drop(3);
    @(negedge clk);
    rst3 = 1'b1;
    @(negedge clk);
    check_reset3("d3_midreset");
    rst3 = 1'b0;
    wait_clear(3, "d3_reclear_cycles");
    issue(3, 1'b0, MEM_W, MEM_UNSIGNED, 32'hC, 32'd0, 32'h0040_0304, 32'd0, 1'b0, 1'b1);
    issue(3, 1'b0, MEM_W, MEM_UNSIGNED, 32'h8, 32'd0, 32'h0040_0308, 32'd0, 1'b0, 1'b1);
    issue(3, 1'b0, MEM_W, MEM_UNSIGNED, 32'h4, 32'd0, 32'h0040_030C, 32'd0, 1'b0, 1'b1);
    drop(3);

    // LATENCY=1, req_valid held: one access per cycle.
    issue(1, 1'b1, MEM_W, MEM_UNSIGNED, 32'h0, 32'h1111_1111, 32'h0000_1000, 32'h1111_1111, 1'b0, 1'b1);
    issue(1, 1'b1, MEM_H, MEM_UNSIGNED, 32'h6, 32'hAAAA_2222, 32'h0000_1004, 32'h2222_0000, 1'b0, 1'b1);
    check("d1_busy_b2b", 32'(busy1), 32'd1);
    issue(1, 1'b1, MEM_B, MEM_UNSIGNED, 32'h9, 32'h5555_5533, 32'h0000_1008, 32'h0000_3300, 1'b0, 1'b1);
    issue(1, 1'b1, MEM_W, MEM_UNSIGNED, 32'hC, 32'h4444_4444, 32'h0000_100C, 32'h4444_4444, 1'b0, 1'b1);
    issue(1, 1'b0, MEM_W, MEM_UNSIGNED, 32'h0, 32'd0, 32'h0000_1010, 32'h1111_1111, 1'b0, 1'b1);
    issue(1, 1'b0, MEM_W, MEM_UNSIGNED, 32'h4, 32'd0, 32'h0000_1014, 32'h2222_0000, 1'b0, 1'b1);
    issue(1, 1'b0, MEM_W, MEM_UNSIGNED, 32'h8, 32'd0, 32'h0000_1018, 32'h0000_3300, 1'b0, 1'b1);
    issue(1, 1'b0, MEM_W, MEM_UNSIGNED, 32'hC, 32'd0, 32'h0000_101C, 32'h4444_4444, 1'b0, 1'b1);
    issue(1, 1'b0, MEM_B, MEM_SIGNED,   32'h7, 32'd0, 32'h0000_1020, 32'h0000_0022, 1'b0, 1'b1);
    issue(1, 1'b0, MEM_H, MEM_SIGNED,   32'h6, 32'd0, 32'h0000_1024, 32'h0000_2222, 1'b0, 1'b1);
    issue(1, 1'b0, MEM_B, MEM_SIGNED,   32'h9, 32'd0, 32'h0000_1028, 32'h0000_0033, 1'b0, 1'b1);
    drop(1);
    @(negedge clk);
    check("d1_busy_resp_idle", 32'(busy1), 32'd0);

    // Drain outstanding expectations.
    n = 0;
    while ((rq3.size() + rq1.size() + lq3.size() + lq1.size()) != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if ((rq3.size() + rq1.size() + lq3.size() + lq1.size()) != 0) begin
      total++; bad++;
      $display("FAIL drain: got %0d responses and %0d logs outstanding, want 0",
               rq3.size() + rq1.size(), lq3.size() + lq1.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
